// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first: one sum bit per clock from a two-half-adder
// full-adder slice with a carry flip-flop, and a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic partS1, partC1, sBit, partC2, carryNext;

  // Full-adder slice: half-adder 1 on the operand bits, half-adder 2 folds in the carry FF.
  assign partS1    = sa_q[0] ^ sb_q[0];
  assign partC1    = sa_q[0] & sb_q[0];
  assign sBit      = partS1 ^ carry_q;
  assign partC2    = partS1 & carry_q;
  assign carryNext = partC1 | partC2;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = carryNext;
        psum_d  = {sBit, psum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        // Last bit: after WIDTH right-shifts the first generated bit has reached bit 0.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {sBit, psum_q[WIDTH-1:1]};
          cout_d  = carryNext;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected {cout,sum} and done cycle,
// a forked monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  typedef struct {
    logic [WIDTH:0] res;
    int             doneCycle;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one start pulse from a negedge; an accepted start is recorded with its done cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic ci, input logic [WIDTH:0] expRes, input bit expectDone);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    if (expectDone) begin
      e.res = expRes;
      e.doneCycle = cycle + 1 + WIDTH;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < WIDTH + 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic runMonitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", {23'd0, cout, sum}, {23'd0, e.res});
          checkOutput("done_latency", cycle, e.doneCycle);
          checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    fork
      runMonitor();
    join_none

    #2;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_sum",  {24'd0, sum}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 0x35 + 0x4A: busy for exactly WIDTH cycles with done low, then the done pulse.
    applyStimulus(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b1);
    for (int i = 1; i < WIDTH; i++) begin
      checkOutput("run_busy", {31'd0, busy}, 32'd1);
      checkOutput("run_done_low", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    checkOutput("last_run_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("sum_held", {24'd0, sum}, 32'h7F);

    applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    waitDone();
    applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
    waitDone();

    // A start during RUN must be ignored.
    applyStimulus(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored_start_busy", {31'd0, busy}, 32'd1);
    waitDone();
    repeat (WIDTH + 2) @(negedge clk);

    // Back-to-back: new start issued in the done cycle of the previous run.
    applyStimulus(8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);
    waitDone();
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    begin
      exp_t e;
      e.res = 9'h003;
      e.doneCycle = cycle + 1 + WIDTH;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    checkOutput("b2b_done_low", {31'd0, done}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_sum_hold", {24'd0, sum}, 32'h10);
    waitDone();

    // Asynchronous reset mid-RUN, between edges.
    applyStimulus(8'h12, 8'h34, 1'b0, 9'h000, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset_busy", {31'd0, busy}, 32'd0);
    checkOutput("areset_done", {31'd0, done}, 32'd0);
    checkOutput("areset_sum",  {24'd0, sum}, 32'd0);
    checkOutput("areset_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
    waitDone();

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc}, 1'b1);
      waitDone();
    end

    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
